// File: rtl/hash_msg_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hash_feeder_pkg
// Description : Shared types and defaults for the hash message feeder.
//               Holds the feeder state encoding, the default message depth,
//               the default watchdog limit and the digest width.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_feeder_pkg;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_WDOG_LIMIT = 16;
    localparam int DIGEST_W           = 32;

    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        DISCARD   = 3'd1,
        FEED      = 3'd2,
        GAP       = 3'd3,
        WAIT_HASH = 3'd4,
        OUT       = 3'd5
    } feeder_state_t;

endpackage : hash_feeder_pkg
`default_nettype wire

// File: rtl/hash_msg_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : hash_msg_feeder_if
// Description : Bundles the host byte stream, the hash-core side and the
//               digest output of the feeder.
//   Ports (as seen by the feeder, modport slave):
//     in_valid/in_ready/in_data/in_last : host byte stream
//     M_valid/message/counter           : byte pulses + length to the core
//     hash_ready/digest_in              : completion and digest from core
//     dig_valid/dig_ready/dig_data      : digest handshake to the consumer
//     ovf_err/wdog_err                  : one-cycle error pulses
//   modport master is the environment (host, core and consumer) side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hash_msg_feeder_if;
    import hash_feeder_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic                in_last;
    logic                M_valid;
    logic [7:0]          message;
    logic [63:0]         counter;
    logic                hash_ready;
    logic [DIGEST_W-1:0] digest_in;
    logic                dig_valid;
    logic                dig_ready;
    logic [DIGEST_W-1:0] dig_data;
    logic                ovf_err;
    logic                wdog_err;

    modport slave (
        input  in_valid, in_data, in_last, hash_ready, digest_in, dig_ready,
        output in_ready, M_valid, message, counter, dig_valid, dig_data,
               ovf_err, wdog_err
    );

    modport master (
        output in_valid, in_data, in_last, hash_ready, digest_in, dig_ready,
        input  in_ready, M_valid, message, counter, dig_valid, dig_data,
               ovf_err, wdog_err
    );

endinterface : hash_msg_feeder_if
`default_nettype wire

// File: rtl/hash_msg_feeder_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous first-word-fall-through byte FIFO. head is valid
//               whenever empty is low. flush clears the FIFO and wins over a
//               simultaneous push/pop.
//   Ports: clk, rst_n (async, active-low), push/din, pop, flush,
//          full, empty, head
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       push,
    input  wire logic [7:0] din,
    input  wire logic       pop,
    input  wire logic       flush,
    output logic            full,
    output logic            empty,
    output logic [7:0]      head
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: a slot is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/hash_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module      : hash_msg_feeder
// Description : Buffers a whole message from a byte stream, then replays it
//               to the hash core as one-cycle M_valid pulses spaced exactly
//               two cycles apart, supplies the 64-bit length and returns the
//               digest through a valid/ready handshake.
//   Ports: clk, rst_n (async, active-low), bus (hash_msg_feeder_if.slave)
//   Option: define HASH_FEEDER_WDOG_EN to enable a WAIT_HASH timeout of
//           WDOG_LIMIT cycles reported on wdog_err; otherwise wdog_err = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_msg_feeder
    import hash_feeder_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WDOG_LIMIT = DEFAULT_WDOG_LIMIT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hash_msg_feeder_if.slave  bus
);

    localparam int LEN_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_LIMIT < 1) begin : g_bad_param
        $error("hash_msg_feeder: DEPTH must be a power of 2 >= 2, WDOG_LIMIT >= 1");
    end

    feeder_state_t       r_state;
    feeder_state_t       w_next;
    logic [LEN_W-1:0]    r_len;
    logic [63:0]         r_counter;
    logic                r_m_valid;
    logic [7:0]          r_message;
    logic                r_dig_valid;
    logic [DIGEST_W-1:0] r_dig_data;
    logic                r_ovf_err;
    logic                r_hash_ready_q;

    logic w_in_ready, w_accept, w_push, w_commit, w_flush, w_done;
    logic w_hash_rise, w_capture, w_wdog_fire;
    logic w_fifo_full, w_fifo_empty;
    logic [7:0] w_head;

    assign w_in_ready  = (r_state == COLLECT) || (r_state == DISCARD);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_push      = (r_state == COLLECT) && w_accept;
    assign w_commit    = w_push && bus.in_last;
    // The DEPTH-th byte without in_last is the overflow point; len never wraps.
    assign w_flush     = w_push && !bus.in_last && (r_len == LEN_W'(DEPTH - 1));
    assign w_hash_rise = bus.hash_ready && !r_hash_ready_q;
    assign w_capture   = (r_state == WAIT_HASH) && w_hash_rise;
    assign w_done      = ((r_state == OUT) && bus.dig_ready) || w_wdog_fire;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push && !w_fifo_full),
        .din   (bus.in_data),
        .pop   (r_state == FEED),
        .flush (w_flush),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_head)
    );

`ifdef HASH_FEEDER_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] r_wdog_cnt;
    logic            r_wdog_err;

    assign w_wdog_fire = (r_state == WAIT_HASH) && !w_hash_rise &&
                         (r_wdog_cnt == WD_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= (r_state == WAIT_HASH) ? r_wdog_cnt + WD_W'(1) : '0;
            r_wdog_err <= w_wdog_fire;
        end
    end

    assign bus.wdog_err = r_wdog_err;
`else
    assign w_wdog_fire  = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            COLLECT: begin
                if (w_commit)     w_next = FEED;
                else if (w_flush) w_next = DISCARD;
            end
            DISCARD:   if (w_accept && bus.in_last) w_next = COLLECT;
            FEED:      w_next = GAP;
            // The idle GAP cycle between bytes is what the core relies on.
            GAP:       w_next = w_fifo_empty ? WAIT_HASH : FEED;
            WAIT_HASH: begin
                if (w_capture)        w_next = OUT;
                else if (w_wdog_fire) w_next = COLLECT;
            end
            OUT:       if (bus.dig_ready) w_next = COLLECT;
            default:   w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len          <= '0;
            r_counter      <= '0;
            r_m_valid      <= 1'b0;
            r_message      <= '0;
            r_dig_valid    <= 1'b0;
            r_dig_data     <= '0;
            r_ovf_err      <= 1'b0;
            r_hash_ready_q <= 1'b0;
        end else begin
            r_hash_ready_q <= bus.hash_ready;
            r_m_valid      <= (r_state == FEED);
            r_dig_valid    <= (w_next == OUT);
            r_ovf_err      <= w_flush;
            if (r_state == FEED) r_message  <= w_head;
            if (w_capture)        r_dig_data <= bus.digest_in;
            if (w_commit)         r_counter  <= 64'(r_len) + 64'd1;
            if (w_flush || w_done) r_len <= '0;
            else if (w_push)       r_len <= r_len + LEN_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.M_valid   = r_m_valid;
    assign bus.message   = r_message;
    assign bus.counter   = r_counter;
    assign bus.dig_valid = r_dig_valid;
    assign bus.dig_data  = r_dig_data;
    assign bus.ovf_err   = r_ovf_err;

endmodule : hash_msg_feeder
`default_nettype wire
